// File: rtl/logic_gate_pkg.sv
// Shared opcode encoding and the bitwise gate evaluator used by every lane of logic_gate_array.
package logic_gate_pkg;

  localparam int OP_W       = 3;
  // Widest lane the evaluator supports; lanes zero-extend into it and truncate the result.
  localparam int GATE_MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } gate_op_e;

  function automatic logic [GATE_MAX_W-1:0] gate_eval(input gate_op_e op,
                                                      input logic [GATE_MAX_W-1:0] a,
                                                      input logic [GATE_MAX_W-1:0] b);
    logic [GATE_MAX_W-1:0] y;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOT_A: y = ~a;
      default:  y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_lane.sv
// One combinational gate lane: applies the lane opcode to WIDTH-bit operands (WIDTH <= 64).
module gate_lane
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  gate_op_e op_e;

  assign op_e = gate_op_e'(op);
  assign y    = WIDTH'(gate_eval(op_e, GATE_MAX_W'(a), GATE_MAX_W'(b)));

endmodule

// File: rtl/logic_gate_array.sv
// CHANNELS-lane, two-stage pipelined gate array with valid/ready on both sides.
// Optional saturating output-beat counter enabled by LOGIC_GATE_ARRAY_STATS_EN.
module logic_gate_array
  import logic_gate_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W*CHANNELS-1:0]   in_op,
  input  logic [WIDTH*CHANNELS-1:0]  in_a,
  input  logic [WIDTH*CHANNELS-1:0]  in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH*CHANNELS-1:0]  out_y,
  output logic [OP_W*CHANNELS-1:0]   out_op
`ifdef LOGIC_GATE_ARRAY_STATS_EN
  ,
  output logic [15:0]                beat_count
`endif
);

  logic                      s1_valid;
  logic [OP_W*CHANNELS-1:0]  s1_op;
  logic [WIDTH*CHANNELS-1:0] s1_a;
  logic [WIDTH*CHANNELS-1:0] s1_b;
  logic                      s2_valid;
  logic [WIDTH*CHANNELS-1:0] lane_y;
  logic                      s1_adv;
  logic                      s2_adv;

  // A stage may advance when it is empty or its downstream slot frees this cycle.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: capture the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= in_op;
        s1_a  <= in_a;
        s1_b  <= in_b;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gate_lane #(.WIDTH(WIDTH)) u_lane (
      .op(s1_op[OP_W*k +: OP_W]),
      .a (s1_a[WIDTH*k +: WIDTH]),
      .b (s1_b[WIDTH*k +: WIDTH]),
      .y (lane_y[WIDTH*k +: WIDTH])
    );
  end

  // Stage 2: register the evaluated result alongside its opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_y    <= '0;
      out_op   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_y  <= lane_y;
        out_op <= s1_op;
      end
    end
  end

`ifdef LOGIC_GATE_ARRAY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count <= 16'd0;
    end else if (s2_valid && out_ready && (beat_count != 16'hFFFF)) begin
      beat_count <= beat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_array.sv
// Scoreboard bench for logic_gate_array: randomized and directed beats against a truth-table model.
module tb_logic_gate_array;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [5:0] in_op, out_op;
  logic [7:0] in_a, in_b, out_y;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_op, b_out_op;
  logic       b_in_a, b_in_b, b_out_y;
`ifdef LOGIC_GATE_ARRAY_STATS_EN
  logic [15:0] beat_count, b_beat_count;
`endif

  always #5 clk = ~clk;

  logic_gate_array #(.WIDTH(4), .CHANNELS(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_op(out_op)
`ifdef LOGIC_GATE_ARRAY_STATS_EN
    , .beat_count(beat_count)
`endif
  );

  logic_gate_array #(.WIDTH(1), .CHANNELS(1)) u_bit (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_op(b_in_op), .in_a(b_in_a), .in_b(b_in_b), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_y(b_out_y), .out_op(b_out_op)
`ifdef LOGIC_GATE_ARRAY_STATS_EN
    , .beat_count(b_beat_count)
`endif
  );

  typedef struct {
    logic [7:0] y;
    logic [5:0] op;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;
  bit   sb_off = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Truth table per opcode, indexed by {a,b}.
  function automatic logic [3:0] tt(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic logic [7:0] model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [3:0] t;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      t = tt(op[3*l +: 3]);
      for (int i = 0; i < 4; i++) r[4*l+i] = t[{a[4*l+i], b[4*l+i]}];
    end
    return r;
  endfunction

  // Monitor: output transfers pop the scoreboard; stalled outputs must hold.
  exp_t       e;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_y;
  logic [5:0] prev_op;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
        chk("stall_y_hold", {24'd0, out_y}, {24'd0, prev_y});
        chk("stall_op_hold", {26'd0, out_op}, {26'd0, prev_op});
      end
      if (out_valid && out_ready && !sb_off) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", {24'd0, out_y}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("out_y", {24'd0, out_y}, {24'd0, e.y});
          chk("out_op", {26'd0, out_op}, {26'd0, e.op});
          if (chk_lat) chk("latency", cyc + 1 - e.acc, 32'd2);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_op    = out_op;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input bit rr, output int w);
    w = 0;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    if (rr) out_ready = 1'($urandom_range(0, 1));
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      if (rr) out_ready = 1'($urandom_range(0, 1));
      #1;
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else sbq.push_back('{ey, op, cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    out_ready = 1'b1;
    while ((sbq.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0 || out_valid) chk("drain_timeout", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int         w;
    logic [5:0] op;
    logic [7:0] a, b;
    logic [3:0] nand_exp;
    nand_exp = 4'b0111;
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; out_ready = 0;
    b_in_valid = 0; b_in_op = 0; b_in_a = 0; b_in_b = 0; b_out_ready = 1;

    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_y", {24'd0, out_y}, 32'd0);
    chk("rst_out_op", {26'd0, out_op}, 32'd0);
`ifdef LOGIC_GATE_ARRAY_STATS_EN
    chk("rst_beat_count", {16'd0, beat_count}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    @(negedge clk);

    // 1-bit NAND sweep, results due two cycles after each accept
    for (int j = 0; j < 6; j++) begin
      b_in_valid = (j < 4);
      b_in_op = 3'd2;
      b_in_a = (j >> 1) & 1;
      b_in_b = j & 1;
      #1;
      if (j < 4) chk("bit_in_ready", {31'd0, b_in_ready}, 32'd1);
      if (j >= 2) begin
        chk("bit_out_valid", {31'd0, b_out_valid}, 32'd1);
        chk("bit_nand_y", {31'd0, b_out_y}, {31'd0, nand_exp[j-2]});
      end
      @(negedge clk);
    end
    b_in_valid = 0;

    // Lane independence and latency
    out_ready = 1'b1;
    chk_lat = 1'b1;
    send(6'b011_100, 8'hA5, 8'h3C, 8'h49, 1'b0, w);
    for (int i = 0; i < 100; i++) begin
      op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b, model(op, a, b), 1'b0, w);
    end
    drain();
    chk_lat = 1'b0;

    // Backpressure: two beats fill the pipe, third must wait
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) send(6'b111_111, 8'(k), 8'($urandom), 8'(k), 1'b0, w);
    in_valid = 1'b1; in_op = 6'b111_111; in_a = 8'd2; in_b = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_out_y_held", {24'd0, out_y}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) send(6'b111_111, 8'(k), 8'($urandom), 8'(k), 1'b0, w);
    drain();

    // Simultaneous drain and fill from a full pipe
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b, model(op, a, b), 1'b0, w);
    end
    out_ready = 1'b1;
    #1 chk("simul_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b, model(op, a, b), 1'b0, w);
      chk("steady_no_wait", w, 32'd0);
    end
    drain();

    // Random backpressure
    for (int i = 0; i < 200; i++) begin
      op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b, model(op, a, b), 1'b1, w);
    end
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op = 6'($urandom); a = 8'($urandom); b = 8'($urandom);
      send(op, a, b, model(op, a, b), 1'b0, w);
    end
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_y", {24'd0, out_y}, 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 chk("post_rst_no_beat", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    send(6'b000_001, 8'hF0, 8'h0F, model(6'b000_001, 8'hF0, 8'h0F), 1'b0, w);
    drain();

`ifdef LOGIC_GATE_ARRAY_STATS_EN
    chk("beat_count_one", {16'd0, beat_count}, 32'd1);
    sb_off = 1'b1;
    in_valid = 1'b1; in_op = 6'd0; in_a = 8'hFF; in_b = 8'hFF;
    repeat (70000) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("beat_count_sat", {16'd0, beat_count}, 32'h0000FFFF);
    rst = 1'b1;
    #1 chk("beat_count_rst", {16'd0, beat_count}, 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    sb_off = 1'b0;
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_gate_array.md
Name: logic_gate_array

Overview:
- Parametrised, pipelined successor to the single two-input NAND gate.
- Applies CHANNELS independent WIDTH-bit bitwise gate operations; each channel has its own run-time opcode.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Sits between a stimulus/producer block and a consumer; also serves as the course's reference gate-evaluation unit.

Parameters:
- WIDTH, 4, operand width per channel in bits (>=1).
- CHANNELS, 2, number of independent lanes (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_op  input  3*CHANNELS  per-lane opcode; lane k at bits [3k+2:3k].
- in_a  input  WIDTH*CHANNELS  operand A; lane k at bits [WIDTH*k +: WIDTH].
- in_b  input  WIDTH*CHANNELS  operand B; same packing as in_a.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- out_y  output  WIDTH*CHANNELS  per-lane result; same packing as in_a.
- out_op  output  3*CHANNELS  opcode echoed alongside its result.

Behaviour:
- Reset: while rst is high, asynchronously clear s1_valid, s2_valid, out_y, out_op and all stage registers to 0. in_ready = 1 after reset.
- Opcodes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR: bitwise on A and B.
  - 6 NOT_A: ~A; B ignored.
  - 7 PASS_A: A; B ignored.
- Stage 1 registers in_op, in_a, in_b and s1_valid.
- Stage 2 computes the result from the stage-1 registers and registers it as out_y/out_op/out_valid.
- Latency: exactly 2 cycles from the accepting edge to out_valid with no stall. Throughput: 1 beat/cycle.
- Handshake:
  - A transfer occurs on an edge where valid && ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no dependence on in_valid).
- Stall: when out_valid && !out_ready, out_y/out_op hold stable and the pipe holds both beats; in_ready drops only once both stages are full.
- Drain/fill are simultaneous-safe: an output transfer and a new input acceptance in the same cycle lose no beat.
- Once asserted, out_valid stays high until the transfer completes. in_* are sampled only on accept.
- Reset mid-operation discards in-flight beats; no output beat after reset release until a new accept.

Optional Feature:
- Macro: LOGIC_GATE_ARRAY_STATS_EN.
- When defined:
  - Extra output port beat_count [15:0], reset to 0.
  - Increments on each output transfer (out_valid && out_ready).
  - Saturates at 16'hFFFF; no wrap.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package logic_gate_pkg holds:
  - typedef enum logic [2:0] gate_op_e (OP_AND…OP_PASS_A, values as above);
  - OP_W = 3;
  - function gate_eval(op, a, b) that returns a WIDTH-bit result.
- One sub-module, gate_lane (single lane, combinational gate_eval wrapper), instantiated CHANNELS times in a generate loop.
- Pipeline and handshake logic stay in the top.

Test Plan:
- Exhaustive 1-bit sweep, WIDTH=1, CHANNELS=1, op=NAND: {a,b}=0..3 with out_ready=1 -> out_y = 1,1,1,0, each 2 cycles after its accept.
- Lane independence, WIDTH=4, CHANNELS=2:
  - stimulus: op lane0=XOR, lane1=NOR; a=8'hA5, b=8'h3C;
  - expect: lane0 = 4'h5 ^ 4'hC = 4'h9; lane1 = ~(4'hA | 4'h3) = 4'h4;
  - result: out_y=8'h49, out_op=6'b011_100.
- Backpressure:
  - stream 4 beats (a=0..3, op=PASS_A) with out_ready=0 -> in_ready low after 2 accepts; out_y=0 held stable.
  - raise out_ready -> outputs 0,1,2,3 in order, with no drops or duplicates.
- Simultaneous events: full pipe, out_ready=1 and in_valid=1 on the same cycle -> one beat leaves, one enters, and in_ready stays 1 at steady state.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately (asynchronous clear), no stale beat after release, in_ready=1.
- STATS_EN: 70000 back-to-back transfers -> beat_count saturates at 16'hFFFF; after rst it reads 0.
